// File: rtl/skid_buffer_dv.sv
// skid_buffer_dv: two-slot registered elastic buffer for a valid/ready pipeline.
// It cuts every combinational path between producer and consumer and sustains
// one token per cycle, with one cycle of latency.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous, active-high reset
//   ins        - upstream token data
//   ins_valid  - upstream token valid
//   ins_ready  - buffer can accept a token (registered)
//   outs       - downstream token data (registered, this is the main slot)
//   outs_valid - downstream token valid (registered)
//   outs_ready - downstream consumer ready
module skid_buffer_dv #(
    parameter int unsigned DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_TYPE-1:0] skid;
    logic                 in_fire_c;
    logic                 out_fire_c;

    // Handshake events; both depend only on registered outputs plus one input.
    assign in_fire_c  = ins_valid & ins_ready;
    assign out_fire_c = outs_valid & outs_ready;

    // State, storage and the registered handshake outputs move together so
    // ins_ready/outs_valid always mirror the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            outs       <= '0;
            skid       <= '0;
            outs_valid <= 1'b0;
            ins_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire_c) begin
                        outs       <= ins;
                        state      <= ONE;
                        outs_valid <= 1'b1;
                        ins_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        outs <= ins;
                    end else if (in_fire_c) begin
                        // Consumer stalled with a token in flight: park it in skid.
                        skid      <= ins;
                        state     <= FULL;
                        ins_ready <= 1'b0;
                    end else if (out_fire_c) begin
                        state      <= EMPTY;
                        outs_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire_c) begin
                        outs      <= skid;
                        state     <= ONE;
                        ins_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    outs_valid <= 1'b0;
                    ins_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_buffer_dv.sv
// Testbench for skid_buffer_dv: three builds (32, 1 and 64 bits) share one
// handshake so their cycle behaviour can be compared directly; a queue-based
// reference model predicts occupancy, handshake outputs and front token.
module tb_skid_buffer_dv;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        outs_ready;

    logic        ins_ready,  outs_valid;
    logic [31:0] outs;
    logic        ins_ready1, outs_valid1;
    logic        outs1;
    logic        ins_ready64, outs_valid64;
    logic [63:0] outs64;

    logic        ins1;
    logic [63:0] ins64;
    assign ins1  = ins[0];
    assign ins64 = {ins, ins};

    int unsigned checks = 0;
    int unsigned errors = 0;

    skid_buffer_dv #(.DATA_TYPE(32)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready));

    skid_buffer_dv #(.DATA_TYPE(1)) dut1 (
        .clk(clk), .rst(rst), .ins(ins1), .ins_valid(ins_valid), .ins_ready(ins_ready1),
        .outs(outs1), .outs_valid(outs_valid1), .outs_ready(outs_ready));

    skid_buffer_dv #(.DATA_TYPE(64)) dut64 (
        .clk(clk), .rst(rst), .ins(ins64), .ins_valid(ins_valid), .ins_ready(ins_ready64),
        .outs(outs64), .outs_valid(outs_valid64), .outs_ready(outs_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of capacity two. Ready means room, valid means
    // non-empty, and the visible token is the oldest one.
    logic [31:0] mq[$];
    int unsigned n_push = 0;

    always @(posedge clk or posedge rst) begin
        bit fi, fo;
        if (rst) begin
            mq.delete();
        end else begin
            fi = ins_valid && (mq.size() < 2);
            fo = (mq.size() > 0) && outs_ready;
            if (fo) void'(mq.pop_front());
            if (fi) begin
                mq.push_back(ins);
                n_push++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        #1;
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial: got v=%b r=%b d=%h expected v=0 r=1 d=0", outs_valid, ins_ready, outs);
        end
        @(negedge clk); rst = 1'b0;
        // Load two tokens while the consumer is stalled.
        ins = 32'h77; ins_valid = 1'b1;
        @(negedge clk); ins = 32'h88;
        @(negedge clk); ins_valid = 1'b0;
        checks++;
        if (ins_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== 32'h77) begin
            errors++;
            $display("FAIL reset_preload_full: got r=%b v=%b d=%h expected r=0 v=1 d=77", ins_ready, outs_valid, outs);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs !== 32'h0 ||
            outs_valid1 !== 1'b0 || ins_ready1 !== 1'b1 || outs1 !== 1'b0 ||
            outs_valid64 !== 1'b0 || ins_ready64 !== 1'b1 || outs64 !== 64'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%b r=%b d=%h d1=%b d64=%h expected all cleared",
                     outs_valid, ins_ready, outs, outs1, outs64);
        end
        @(negedge clk); rst = 1'b0;
        ins = 32'h11; ins_valid = 1'b1; outs_ready = 1'b1;
        @(negedge clk); ins_valid = 1'b0;
        checks++;
        if (outs_valid !== 1'b1 || outs !== 32'h11) begin
            errors++;
            $display("FAIL reset_first_token: got v=%b d=%h expected v=1 d=11", outs_valid, outs);
        end
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain: got v=%b r=%b expected v=0 r=1", outs_valid, ins_ready);
        end
    endtask

    task automatic test_streaming();
        outs_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (ins_ready !== 1'b1 || ins_ready1 !== 1'b1 || ins_ready64 !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got r=%b/%b/%b expected 1", i, ins_ready, ins_ready1, ins_ready64);
            end
            if (i > 0) begin
                checks++;
                if (outs_valid !== 1'b1 || outs !== 32'(i) || outs1 !== 1'(i) ||
                    outs64 !== {32'(i), 32'(i)} || outs_valid1 !== 1'b1 || outs_valid64 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_data[%0d]: got v=%b d=%h d1=%b d64=%h expected %h",
                             i, outs_valid, outs, outs1, outs64, 32'(i));
                end
            end
            ins = 32'(i + 1);
            ins_valid = (i < 16);
        end
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got v=%b expected 0", outs_valid);
        end
    endtask

    task automatic test_stall(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); ins = a; ins_valid = 1'b1; outs_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b1 || outs !== a) begin
            errors++;
            $display("FAIL stall_first: got v=%b d=%h expected v=1 d=%h", outs_valid, outs, a);
        end
        ins = b; outs_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); ins_valid = 1'b0;
            checks++;
            if (ins_ready !== 1'b0 || ins_ready1 !== 1'b0 || ins_ready64 !== 1'b0 ||
                outs_valid !== 1'b1 || outs !== a || outs1 !== a[0] || outs64 !== {a, a}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got r=%b v=%b d=%h d1=%b d64=%h expected r=0 v=1 d=%h",
                         k, ins_ready, outs_valid, outs, outs1, outs64, a);
            end
        end
        outs_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b1 || outs !== b || outs1 !== b[0] || outs64 !== {b, b} ||
            ins_ready !== 1'b1 || ins_ready1 !== 1'b1 || ins_ready64 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got r=%b v=%b d=%h d1=%b d64=%h expected r=1 v=1 d=%h",
                     ins_ready, outs_valid, outs, outs1, outs64, b);
        end
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b0 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_drain: got v=%b r=%b expected v=0 r=1", outs_valid, ins_ready);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); ins = 32'h5; ins_valid = 1'b1; outs_ready = 1'b1;
        @(negedge clk); ins = 32'h6;
        checks++;
        if (outs !== 32'h5 || outs_valid !== 1'b1) begin
            errors++;
            $display("FAIL simul_main: got v=%b d=%h expected v=1 d=5", outs_valid, outs);
        end
        @(negedge clk); ins_valid = 1'b0;
        checks++;
        if (outs !== 32'h6 || outs_valid !== 1'b1 || ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_pass: got v=%b r=%b d=%h expected v=1 r=1 d=6", outs_valid, ins_ready, outs);
        end
        @(negedge clk);
        checks++;
        if (outs_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: got v=%b expected 0", outs_valid);
        end
    endtask

    task automatic test_width_patterns();
        logic [31:0] pat [3];
        pat[0] = 32'h0; pat[1] = 32'h1; pat[2] = 32'hFFFF_FFFF;
        outs_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (outs_valid1 !== 1'b1 || outs_valid64 !== 1'b1 || outs1 !== pat[i-1][0] ||
                    outs64 !== {pat[i-1], pat[i-1]} || outs !== pat[i-1]) begin
                    errors++;
                    $display("FAIL width_stream[%0d]: got d1=%b d64=%h d=%h expected %h",
                             i, outs1, outs64, outs, pat[i-1]);
                end
            end
            if (i < 3) ins = pat[i];
            ins_valid = (i < 3);
        end
        @(negedge clk);
        test_stall(32'hFFFF_FFFF, 32'h0);
        test_stall(32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_random_backpressure();
        int unsigned base;
        int unsigned cycles;
        int unsigned delivered;
        bit exp_v, exp_r;
        base = n_push; cycles = 0; delivered = 0;
        ins_valid = 1'b0; outs_ready = 1'b0;
        while (!((n_push - base) >= 1000 && mq.size() == 0)) begin
            @(negedge clk);
            cycles++;
            if (cycles > 20000) begin
                checks++; errors++;
                $display("FAIL random_timeout: got %0d tokens expected 1000", n_push - base);
                break;
            end
            exp_v = (mq.size() > 0);
            exp_r = (mq.size() < 2);
            checks++;
            if (outs_valid !== exp_v || ins_ready !== exp_r || outs_valid1 !== exp_v ||
                ins_ready1 !== exp_r || outs_valid64 !== exp_v || ins_ready64 !== exp_r) begin
                errors++;
                $display("FAIL random_hs[%0d]: got v=%b r=%b expected v=%b r=%b",
                         cycles, outs_valid, ins_ready, exp_v, exp_r);
            end
            if (exp_v) begin
                checks++;
                if (outs !== mq[0] || outs1 !== mq[0][0] || outs64 !== {mq[0], mq[0]}) begin
                    errors++;
                    $display("FAIL random_data[%0d]: got d=%h d1=%b d64=%h expected %h",
                             cycles, outs, outs1, outs64, mq[0]);
                end
            end
            ins = $urandom;
            ins_valid = ((n_push - base) < 1000) && ($urandom_range(1, 0) == 1);
            outs_ready = ($urandom_range(1, 0) == 1);
            if (outs_valid === 1'b1 && outs_ready) delivered++;
        end
        ins_valid = 1'b0;
        checks++;
        if (delivered != 1000) begin
            errors++;
            $display("FAIL random_count: got %0d deliveries expected 1000", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall(32'hA, 32'hB);
        test_simultaneous();
        test_width_patterns();
        test_random_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_buffer_dv.md
# skid_buffer_dv

Two-slot registered elastic buffer for the handshake pipeline, placed directly downstream of a combinational arithmetic unit such as the XOR stage. It consumes the unit's result/valid and drives its ready. It breaks every combinational path between its two sides:
- valid and data toward the consumer are registered;
- ready toward the producer is registered.

Full throughput is preserved (one token per cycle), with one cycle of latency.

## Interface
Parameters:
- DATA_TYPE, default 32: token data width in bits (≥1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ins  input  DATA_TYPE  upstream token data (e.g. XOR result).
- ins_valid  input  1  upstream token valid.
- ins_ready  output  1  buffer can accept a token; registered.
- outs  output  DATA_TYPE  downstream token data; registered.
- outs_valid  output  1  downstream token valid; registered.
- outs_ready  input  1  downstream consumer ready.

## Operation
- Storage consists of two registers:
  - main: drives outs;
  - skid: overflow slot, holds a token when downstream stalls.
- Handshake events:
  - in_fire = ins_valid & ins_ready;
  - out_fire = outs_valid & outs_ready.
- States and their outputs:
  - EMPTY: outs_valid=0, ins_ready=1.
  - ONE (main full): outs_valid=1, ins_ready=1.
  - FULL (main+skid): outs_valid=1, ins_ready=0.
- Transitions:
  - EMPTY, in_fire → ONE, main<=ins.
  - EMPTY, no in_fire → EMPTY.
  - ONE, in_fire & out_fire → ONE, main<=ins.
  - ONE, in_fire & !out_fire → FULL, skid<=ins, main unchanged.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, neither → ONE.
  - FULL, out_fire → ONE, main<=skid.
  - FULL, no out_fire → FULL. No in_fire is possible here, since ins_ready=0.
- Ordering is strict FIFO. No token is ever dropped, duplicated or reordered.
- Data is passed bit-for-bit; no width conversion.
- ins_ready and outs_valid are decoded directly from the state register only. There is no combinational path from any input to any output.

## Timing
- Reset (async assert, released synchronously with clk):
  - state=EMPTY;
  - outs_valid=0;
  - ins_ready=1;
  - outs=0;
  - skid=0.
- Reset mid-operation: both held tokens are discarded immediately and outputs take their reset values within the same cycle as rst assertion, without waiting for a clock edge.
- Latency: a token accepted at edge N is visible on outs with outs_valid=1 in the cycle after edge N.
- Throughput: with outs_ready held at 1, one token per cycle is sustained indefinitely; state stays ONE.
- Stall: outs_ready=0 while in ONE with a new input → FULL after one edge. ins_ready falls one cycle after the stall begins; the skid slot absorbs the token in flight.
- Release: outs_ready rising in FULL → the skid token moves to main on that edge. ins_ready=1 in the following cycle.
- While outs_valid=1 and out_fire has not occurred, outs and outs_valid are stable (AXI-style hold rule).
- ins_valid may drop without a transfer; the buffer imposes no upstream hold requirement.

## Test plan
- Reset: assert rst mid-run holding two tokens.
  - Required: outs_valid=0, ins_ready=1, outs=0 immediately, without a clock edge.
  - Required: after release, the first new token 0x11 appears one cycle after acceptance.
- Streaming: send 0x00000001..0x00000010 back-to-back, outs_ready=1 constant.
  - Required: 16 outputs in order, one per cycle, first output at cycle 1 after first accept.
  - Required: ins_ready never drops.
- Stall/skid: send 0xA, 0xB on consecutive cycles, outs_ready=0 from the cycle after 0xA is accepted.
  - Required: state FULL, ins_ready=0, outs=0xA held stable.
  - Raise outs_ready. Required: 0xA then 0xB delivered on consecutive cycles, then ins_ready=1.
- Simultaneous in/out in ONE: main=0x5, outs_ready=1, ins=0x6 valid.
  - Required: state stays ONE, outs=0x6 next cycle, no skid use.
- Random backpressure: 1000 random tokens, ins_valid and outs_ready each random at 50%.
  - Required: scoreboard shows an exact in-order match and no loss.
  - Required: ins_ready is never 1 in FULL; outs stable during stalls.
- DATA_TYPE=1 and DATA_TYPE=64 builds: repeat the streaming and stall scenarios with patterns 0/1 and 0xFFFFFFFFFFFFFFFF.
  - Required: identical cycle behaviour and exact data.
